// File: rtl/md5_ui_pkg.sv
// md5_ui_pkg: shared buffer size, FSM states and display codes for the message entry UI
package md5_ui_pkg;
  localparam int BYTES = 16;
  typedef enum logic [1:0] {EDIT, START, BUSY} state_t;
  localparam logic [4:0] BLANK_SEG = 5'b10000;
  localparam logic [4:0] END_SEG = 5'b11111;
endpackage

// File: rtl/in_prefix_len.sv
// in_prefix_len: count of consecutive set valid bits starting at bit 0
module in_prefix_len #(
  parameter int BYTES = 16
) (
  input  logic [BYTES-1:0]       valid,
  output logic [$clog2(BYTES):0] len
);
  logic run;
  // a running AND stops counting at the first hole
  always_comb begin
    len = '0;
    run = 1'b1;
    for (int i = 0; i < BYTES; i++) begin
      run = run & valid[i];
      len = len + ($clog2(BYTES)+1)'(run);
    end
  end
endmodule

// File: rtl/in_window.sv
// in_window: hex-keypad message entry buffer with hand-off to a hash core (optional seg_echo via IN_WINDOW_ECHO_EN)
module in_window #(
  parameter int BYTES = md5_ui_pkg::BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [3:0]               key_nibble,
  input  logic                     left_shift,
  input  logic                     right_shift,
  input  logic                     clear,
  input  logic                     go,
  input  logic                     core_done,
  output logic [8*BYTES-1:0]       data_o,
  output logic [BYTES-1:0]         valid_o,
  output logic [$clog2(BYTES)-1:0] cursor_o,
  output logic                     nib_hi_o,
  output logic [$clog2(BYTES):0]   len_o,
  output logic                     start_o,
  output logic                     busy_o
`ifdef IN_WINDOW_ECHO_EN
  ,
  output logic [4:0]               seg_echo
`endif
);
  import md5_ui_pkg::*;
  localparam int CW = $clog2(BYTES);
  localparam logic [CW-1:0] LAST = CW'(BYTES-1);
  state_t state, next_state;
  logic edit;
  assign edit = state == EDIT;
  in_prefix_len #(.BYTES(BYTES)) u_len (.valid(valid_o), .len(len_o));
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= EDIT;
    else state <= next_state;
  end
  // go needs a non-empty buffer and no concurrent clear; START is a single cycle
  always_comb begin
    next_state = edit ? ((go && !clear && len_o != '0) ? START : EDIT) :
                 state == START ? BUSY :
                 core_done ? EDIT : BUSY;
  end
  // handshake outputs decoded from state
  always_comb begin
    start_o = state == START;
    busy_o  = !edit;
  end
  // buffer edits only in EDIT; clear beats keys, keys beat shifts
  always_ff @(posedge clk) begin
    if (rst || (edit && clear)) begin
      data_o   <= '0;
      valid_o  <= '0;
      cursor_o <= '0;
      nib_hi_o <= 1'b0;
    end else if (edit && key_valid) begin
      data_o[{cursor_o, nib_hi_o, 2'b00} +: 4] <= key_nibble;
      nib_hi_o <= !nib_hi_o;
      if (nib_hi_o) begin
        valid_o[cursor_o] <= 1'b1;
        cursor_o <= cursor_o == LAST ? cursor_o : cursor_o + CW'(1);
      end
    end else if (edit && (left_shift ^ right_shift)) begin
      cursor_o <= left_shift ? (cursor_o == LAST ? cursor_o : cursor_o + CW'(1)) :
                               (cursor_o == '0 ? cursor_o : cursor_o - CW'(1));
      nib_hi_o <= 1'b0;
    end
  end
`ifdef IN_WINDOW_ECHO_EN
  // echo the nibble under the cursor once its byte is complete, else blank
  always_ff @(posedge clk) begin
    if (rst) seg_echo <= BLANK_SEG;
    else seg_echo <= valid_o[cursor_o] ? {1'b0, data_o[{cursor_o, nib_hi_o, 2'b00} +: 4]} : BLANK_SEG;
  end
`endif
endmodule

// File: tb/tb_in_window.sv
// tb_in_window: directed checks of entry, cursor, handshake and reset behaviour
module tb_in_window;
  logic clk = 1'b0;
  logic rst, key_valid, left_shift, right_shift, clear, go, core_done;
  logic [3:0] key_nibble;
  logic [127:0] data_o;
  logic [15:0] valid_o;
  logic [3:0] cursor_o;
  logic nib_hi_o, start_o, busy_o;
  logic [4:0] len_o;
  int n_checks = 0;
  int n_errors = 0;
  in_window #(.BYTES(16)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_nibble(key_nibble),
    .left_shift(left_shift), .right_shift(right_shift), .clear(clear), .go(go),
    .core_done(core_done), .data_o(data_o), .valid_o(valid_o), .cursor_o(cursor_o),
    .nib_hi_o(nib_hi_o), .len_o(len_o), .start_o(start_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    {rst, key_valid, left_shift, right_shift, clear, go, core_done} = '0;
  endtask
  task automatic key(input logic [3:0] n);
    key_valid = 1'b1;
    key_nibble = n;
    step();
  endtask
  initial begin
    {key_valid, left_shift, right_shift, clear, go, core_done} = '0;
    key_nibble = '0;
    rst = 1'b1;
    step();
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_cursor", cursor_o, 0);
    check("rst_nib", nib_hi_o, 0);
    check("rst_start", start_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_len", len_o, 0);
    key(4'hA);
    check("lo_nib_hi", nib_hi_o, 1);
    check("lo_data", data_o, 128'h0A);
    key(4'h5);
    check("b0_data", data_o, 128'h5A);
    check("b0_valid", valid_o, 16'h0001);
    check("b0_cursor", cursor_o, 1);
    check("b0_nib", nib_hi_o, 0);
    check("b0_len", len_o, 1);
    clear = 1'b1;
    step();
    check("clr_data", data_o, 0);
    check("clr_valid", valid_o, 0);
    check("clr_cursor", cursor_o, 0);
    for (int i = 0; i < 17; i++) begin
      left_shift = 1'b1;
      step();
    end
    check("sat_hi", cursor_o, 15);
    left_shift = 1'b1;
    right_shift = 1'b1;
    step();
    check("both_shift", cursor_o, 15);
    key(4'h1);
    key_valid = 1'b1;
    key_nibble = 4'h2;
    right_shift = 1'b1;
    step();
    check("b15_valid", valid_o, 16'h8000);
    check("b15_cursor", cursor_o, 15);
    check("b15_nib", nib_hi_o, 0);
    check("b15_len", len_o, 0);
    check("b15_data", data_o, {8'h21, 120'h0});
    right_shift = 1'b1;
    step();
    check("rs_cursor", cursor_o, 14);
    key(4'h3);
    check("b14_nib", nib_hi_o, 1);
    right_shift = 1'b1;
    step();
    check("shift_nib", nib_hi_o, 0);
    check("shift_cursor", cursor_o, 13);
    check("b14_data", data_o, {16'h2103, 112'h0});
    for (int i = 0; i < 16; i++) begin
      right_shift = 1'b1;
      step();
    end
    check("sat_lo", cursor_o, 0);
    clear = 1'b1;
    key_valid = 1'b1;
    key_nibble = 4'h7;
    step();
    check("clrkey_data", data_o, 0);
    check("clrkey_valid", valid_o, 0);
    check("clrkey_nib", nib_hi_o, 0);
    go = 1'b1;
    step();
    check("empty_go_start", start_o, 0);
    check("empty_go_busy", busy_o, 0);
    step();
    check("empty_go_start2", start_o, 0);
    key(4'h1); key(4'h1); key(4'h2); key(4'h2); key(4'h3); key(4'h3);
    check("fill_data", data_o, 128'h332211);
    check("fill_len", len_o, 3);
    go = 1'b1;
    step();
    check("go_start", start_o, 1);
    check("go_busy", busy_o, 1);
    step();
    check("busy_start", start_o, 0);
    check("busy_busy", busy_o, 1);
    key(4'hF);
    check("busy_key_data", data_o, 128'h332211);
    check("busy_key_cursor", cursor_o, 3);
    clear = 1'b1;
    go = 1'b1;
    step();
    check("busy_clr_valid", valid_o, 16'h0007);
    check("busy_go_start", start_o, 0);
    core_done = 1'b1;
    step();
    check("done_busy", busy_o, 0);
    check("done_data", data_o, 128'h332211);
    check("done_cursor", cursor_o, 3);
    clear = 1'b1;
    step();
    key(4'h1); key(4'h1); key(4'h2); key(4'h2);
    left_shift = 1'b1;
    step();
    key(4'h4); key(4'h4);
    check("gap_valid", valid_o, 16'h000B);
    check("gap_len", len_o, 2);
    clear = 1'b1;
    go = 1'b1;
    step();
    check("clrgo_start", start_o, 0);
    check("clrgo_data", data_o, 0);
    key(4'h9); key(4'h8);
    go = 1'b1;
    step();
    check("go2_start", start_o, 1);
    step();
    rst = 1'b1;
    step();
    check("midrst_busy", busy_o, 0);
    check("midrst_start", start_o, 0);
    check("midrst_data", data_o, 0);
    check("midrst_valid", valid_o, 0);
    core_done = 1'b1;
    step();
    check("late_done_busy", busy_o, 0);
    check("late_done_start", start_o, 0);
    step();
    check("late_done_start2", start_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
